// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, shifts executed one bit per cycle.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, n+1 cycles for a shift by n.
// Backpressure: none; start is ignored while busy, so the requester must wait for done.
module iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] work;
  logic [4:0]      cnt;
  logic [XLEN-1:0] imm_result;
  logic [XLEN-1:0] step;
  logic            is_shift;
  logic [4:0]      shamt;

  assign shamt    = b[4:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign zero     = (result == '0);

  // Single-cycle result from the live operands; a shift reaching here has amount 0 and returns a.
  always_comb begin
    imm_result = '0;
    case (alu_ctrl)
      OP_ADD:  imm_result = a + b;
      OP_SUB:  imm_result = a - b;
      OP_AND:  imm_result = a & b;
      OP_OR:   imm_result = a | b;
      OP_XOR:  imm_result = a ^ b;
      OP_SLT:  imm_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: imm_result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  imm_result = a;
      default: imm_result = '0;
    endcase
  end

  // One-bit shift of the working register according to the latched opcode.
  always_comb begin
    step = work;
    case (op_q)
      OP_SLL:  step = {work[XLEN-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work[XLEN-1:1]};
      OP_SRA:  step = {work[XLEN-1], work[XLEN-1:1]};
      default: step = work;
    endcase
  end

  // Control FSM with registered busy/done; result only moves when a done pulse is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= 4'd0;
      work   <= '0;
      cnt    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= alu_ctrl;
            busy <= 1'b1;
            if (is_shift && (shamt != 5'd0)) begin
              work  <= a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result <= imm_result;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= step;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: behavioural latency/result model checked every cycle,
// plus directed vectors with literal expected results and latencies.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad = 0;

  iterative_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each opcode.
  function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [4:0] s;
    s = y[4:0];
    case (c)
      4'b0000: ref_op = x + y;
      4'b0001: ref_op = x - y;
      4'b0010: ref_op = x & y;
      4'b0011: ref_op = x | y;
      4'b0100: ref_op = x ^ y;
      4'b0101: ref_op = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1001: ref_op = (x < y) ? 32'd1 : 32'd0;
      4'b0110: ref_op = x << s;
      4'b0111: ref_op = x >> s;
      4'b1000: ref_op = $signed(x) >>> s;
      default: ref_op = 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y);
    if ((c == 4'b0110 || c == 4'b0111 || c == 4'b1000) && y[4:0] != 5'd0)
      ref_lat = int'(y[4:0]) + 1;
    else
      ref_lat = 1;
  endfunction

  // Model: cycles remaining until the operation retires; done on the last one.
  int          rem_m = 0;
  logic [31:0] pend_m = 32'd0;
  logic [31:0] res_m = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_m = 0;
      res_m = 32'd0;
    end else if (rem_m == 0) begin
      if (start) begin
        pend_m = ref_op(alu_ctrl, a, b);
        rem_m  = ref_lat(alu_ctrl, b);
        if (rem_m == 1) res_m = pend_m;
      end
    end else begin
      rem_m--;
      if (rem_m == 1) res_m = pend_m;
    end
  end

  always @(negedge clk) begin
    check("m_busy",   {31'd0, busy},   {31'd0, (rem_m != 0)});
    check("m_done",   {31'd0, done},   {31'd0, (rem_m == 1)});
    check("m_result", result,          res_m);
    check("m_zero",   {31'd0, zero},   {31'd0, (res_m == 32'd0)});
  end

  // Issue one op from idle, measure cycles to done, check literal result and latency.
  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    @(posedge clk);
    #1;
    alu_ctrl = c; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = ~y; alu_ctrl = ~c;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    check({name, "_lat"}, cyc, exp_lat);
    check({name, "_res"}, result, exp_res);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
  endtask

  initial begin
    int ndone;
    int done_cyc;

    rst = 1'b1;
    @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result,        32'd0);
    check("rst_zero",   {31'd0, zero}, 32'd1);
    rst = 1'b0;

    run_op("add_wrap",  4'b0000, 32'h7FFF_FFFF, 32'd1,  32'h8000_0000, 1);
    run_op("sub_zero",  4'b0001, 32'd5,         32'd5,  32'd0,         1);
    run_op("slt",       4'b0101, 32'hFFFF_FFFF, 32'd1,  32'd1,         1);
    run_op("sltu",      4'b1001, 32'hFFFF_FFFF, 32'd1,  32'd0,         1);
    run_op("sra31",     4'b1000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31",     4'b0111, 32'h8000_0000, 32'd31, 32'd1,         32);
    run_op("sll0",      4'b0110, 32'h1234,      32'h20, 32'h1234,      1);
    run_op("and",       4'b0010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1);
    run_op("or",        4'b0011, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1);
    run_op("xor",       4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_op("undef",     4'b1010, 32'd7,         32'd9,  32'd0,         1);
    run_op("sll1",      4'b0110, 32'h8000_0001, 32'd1,  32'd2,         2);
    run_op("sra4",      4'b1000, 32'h7000_0000, 32'd4,  32'h0700_0000, 5);

    // Start while busy: ADD on cycle 2 of an SLL by 4 must be dropped.
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0110; a = 32'd1; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    done_cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = i;
      end
      if (i == 1) begin
        alu_ctrl = 4'b0000; a = 32'd2; b = 32'd3; start = 1'b1;
      end else if (i == 2) begin
        start = 1'b0;
      end
    end
    check("busy_ign_ndone", ndone,    32'd1);
    check("busy_ign_cyc",   done_cyc, 32'd5);
    check("busy_ign_res",   result,   32'h10);

    // Reset in the middle of an SRL by 10: immediate clear, no done afterwards.
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0111; a = 32'hFFFF_0000; b = 32'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_result", result,        32'd0);
    check("midrst_zero",   {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_nodone", ndone, 32'd0);
    run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported, and shift amounts use the low 5 bits of b.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled on the rising edge of clk.
REQ-005 alu_ctrl  input  4  operation code, consumed exactly as produced by the ALU control decoder.
REQ-006 a  input  XLEN  operand A (rs1).
REQ-007 b  input  XLEN  operand B (rs2 or immediate).
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking that result is valid for the completed operation.
REQ-010 result  output  XLEN  registered result of the last completed operation.
REQ-011 zero  output  1  (result == 0), derived from the result register.

Function
REQ-012 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, result 1/0), 1001 SLTU (unsigned, result 1/0), 0110 SLL, 0111 SRL, 1000 SRA; codes 1010-1111 yield result 0.
REQ-013 FSM states: IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-014 Acceptance: start=1 in IDLE latches alu_ctrl, a, and b; start in SHIFT or DONE is ignored, with no queueing.
REQ-015 Non-shift ops and shifts with b[4:0]==0: the result register loads in the accept cycle, IDLE->DONE, and done=1 in the next cycle (latency 1).
REQ-016 Shifts with shamt=n>0: the accept cycle loads a into the working register and n into a 5-bit down-counter, IDLE->SHIFT.
REQ-017 SHIFT state: one bit position per cycle (SLL: <<1 with zero fill; SRL: >>1 with zero fill; SRA: >>1 replicating bit 31), counter decrements each cycle.
REQ-018 When the counter reaches 1 in SHIFT, the final step writes result and the FSM goes SHIFT->DONE; total latency start->done = n+1 cycles (max 32 for n=31).
REQ-019 DONE lasts exactly one cycle with done=1, then DONE->IDLE unconditionally; start during DONE is ignored.
REQ-020 result and zero hold their values from one done pulse until the next done pulse; result does not change during SHIFT.
REQ-021 ADD/SUB wrap modulo 2^32 with no overflow or carry output.
REQ-022 Operand or alu_ctrl changes after acceptance do not affect the in-flight operation.

Reset
REQ-023 rst=1 immediately forces state=IDLE, busy=0, done=0, result=0, zero=1, counter=0, working register=0, regardless of clock.
REQ-024 Reset during SHIFT or DONE aborts the operation without a done pulse; the first start after rst deasserts is accepted normally.

Verification
REQ-025 ADD: a=0x7FFFFFFF, b=1, start -> next cycle done=1, result=0x80000000, zero=0; busy=1 for exactly one cycle.
REQ-026 SUB/zero: a=5, b=5, ctrl=0001 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-027 SRA: a=0x80000000, b=31 -> busy=1 for 32 cycles, done on cycle 32, result=0xFFFFFFFF; SRL with the same operands -> result=1.
REQ-028 SLL with shamt 0: a=0x1234, b=0x20 -> done after 1 cycle, result=0x1234.
REQ-029 Start while busy: SLL a=1, b=4, then start ADD on cycle 2 -> ADD is ignored, result=0x10 at done (cycle 5), and no second done pulse.
REQ-030 Reset mid-shift: SRL b=10, rst asserted on cycle 3 -> busy=0, result=0 immediately, no done; next ADD a=2, b=3 -> result=5.
